db_bs: RTL and testbench

- Boundary-strength (BS) stage directly downstream of the deblocking MV fetch stage.
- Consumes the P/Q motion-vector pair stream produced during DBY, together with aligned edge/coding flags, and computes a 2-bit HEVC BS per edge sample.
- Stores the BS values for one CTU in a 256-entry register file that the luma/chroma filter stage reads by address.
- Raises a done pulse when the CTU's BS map is complete.

---
 rtl/db_bs.sv | 229 ++++++++++++++++++++++
 tb/tb_db_bs.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/db_bs.sv
// rtl/db_bs.sv - HEVC deblocking boundary-strength stage with per-CTU BS register file
//
// Computes a 2-bit boundary strength for every P/Q edge sample streamed
// during the DBY pass and stores it in a 256-entry register file indexed
// by the originating cycle counter. The filter stage reads the map by address.
//
// Optional build macro: DB_BS_STAT_EN adds per-value BS counters for the pass.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   state_i, cnt_i           deblock top FSM state and cycle counter
//   sys_ctu_x_i/sys_ctu_y_i  current CTU position (picture-edge suppression)
//   mv_p_i, mv_q_i           {mvx, mvy} P/Q motion vectors, two cycles behind cnt_i
//   edge_tu_i .. intra_q_i   edge/coding flags aligned with the MV pair
//   bs_raddr_i, bs_rdata_o   register-file read port, 1-cycle latency
//   bs_o, bs_valid_o         BS of the current stream sample and its strobe
//   bs_done_o                pulse after entry 255 has been written
//   bs2/bs1/bs0_cnt_o        (DB_BS_STAT_EN) BS histogram of the current pass

`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif
`ifndef PIC_Y_WIDTH
`define PIC_Y_WIDTH 8
`endif

module db_bs #(
    parameter int MV_W   = 10,
    parameter int MV_THR = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              state_i,
    input  logic [8:0]              cnt_i,
    input  logic [`PIC_X_WIDTH-1:0] sys_ctu_x_i,
    input  logic [`PIC_Y_WIDTH-1:0] sys_ctu_y_i,
    input  logic [2*MV_W-1:0]       mv_p_i,
    input  logic [2*MV_W-1:0]       mv_q_i,
    input  logic                    edge_tu_i,
    input  logic                    edge_pu_i,
    input  logic                    cbf_p_i,
    input  logic                    cbf_q_i,
    input  logic                    intra_p_i,
    input  logic                    intra_q_i,
    input  logic [7:0]              bs_raddr_i,
    output logic [1:0]              bs_rdata_o,
    output logic [1:0]              bs_o,
    output logic                    bs_valid_o,
    output logic                    bs_done_o
`ifdef DB_BS_STAT_EN
    ,
    output logic [8:0]              bs2_cnt_o,
    output logic [8:0]              bs1_cnt_o,
    output logic [8:0]              bs0_cnt_o
`endif
);

    localparam logic [2:0] ST_DBY = 3'b011;
    localparam int         DW     = MV_W + 1;

    // |a-b| of two signed MV components; one extra bit makes the
    // difference and its magnitude exact for the full component range.
    function automatic logic [DW-1:0] abs_diff(input logic [MV_W-1:0] a,
                                               input logic [MV_W-1:0] b);
        logic [DW-1:0] d;
        d = {a[MV_W-1], a} - {b[MV_W-1], b};
        return d[DW-1] ? ((~d) + DW'(1)) : d;
    endfunction

    // ------------------------------------------------------------------
    // Accept window: valid bit and address follow cnt_i by two cycles so
    // they line up with the MV pair coming out of the fetch stage.
    // ------------------------------------------------------------------
    logic       v_d1, v_d2;
    logic [7:0] cnt_d1, cnt_d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_d1   <= 1'b0;
            v_d2   <= 1'b0;
            cnt_d1 <= '0;
            cnt_d2 <= '0;
        end else begin
            v_d1   <= (state_i == ST_DBY) && !cnt_i[8];
            cnt_d1 <= cnt_i[7:0];
            v_d2   <= v_d1;
            cnt_d2 <= cnt_d1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: MV differences and flag capture
    // ------------------------------------------------------------------
    logic          s1_valid;
    logic [7:0]    s1_addr;
    logic [DW-1:0] s1_dx, s1_dy;
    logic          s1_tu, s1_pu, s1_cbf_p, s1_cbf_q, s1_intra_p, s1_intra_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s1_dx      <= '0;
            s1_dy      <= '0;
            s1_tu      <= 1'b0;
            s1_pu      <= 1'b0;
            s1_cbf_p   <= 1'b0;
            s1_cbf_q   <= 1'b0;
            s1_intra_p <= 1'b0;
            s1_intra_q <= 1'b0;
        end else begin
            s1_valid <= v_d2;
            if (v_d2) begin
                s1_addr    <= cnt_d2;
                s1_dx      <= abs_diff(mv_p_i[2*MV_W-1:MV_W], mv_q_i[2*MV_W-1:MV_W]);
                s1_dy      <= abs_diff(mv_p_i[MV_W-1:0], mv_q_i[MV_W-1:0]);
                s1_tu      <= edge_tu_i;
                s1_pu      <= edge_pu_i;
                s1_cbf_p   <= cbf_p_i;
                s1_cbf_q   <= cbf_q_i;
                s1_intra_p <= intra_p_i;
                s1_intra_q <= intra_q_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 decision. Address layout: [7:5] row, [4:2] column, [1:0]
    // phase; phases 0/1 are vertical edges, 2/3 horizontal edges.
    // ------------------------------------------------------------------
    logic [1:0] bs_next;
    logic       pic_col_edge, pic_row_edge;

    always_comb begin
        pic_col_edge = (sys_ctu_x_i == '0) && (s1_addr[4:2] == 3'd0) && !s1_addr[1];
        pic_row_edge = (sys_ctu_y_i == '0) && (s1_addr[7:5] == 3'd0) &&  s1_addr[1];
        bs_next      = 2'd0;
        if (!(s1_tu || s1_pu))
            bs_next = 2'd0;
        else if (pic_col_edge || pic_row_edge)
            bs_next = 2'd0;
        else if (s1_intra_p || s1_intra_q)
            bs_next = 2'd2;
        else if (s1_tu && (s1_cbf_p || s1_cbf_q))
            bs_next = 2'd1;
        else if ((s1_dx >= DW'(MV_THR)) || (s1_dy >= DW'(MV_THR)))
            bs_next = 2'd1;
        else
            bs_next = 2'd0;
    end

    logic [7:0] wr_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bs_o       <= 2'd0;
            bs_valid_o <= 1'b0;
            wr_addr    <= '0;
        end else begin
            bs_o       <= s1_valid ? bs_next : 2'd0;
            bs_valid_o <= s1_valid;
            wr_addr    <= s1_addr;
        end
    end

    // ------------------------------------------------------------------
    // Register file: written at the end of the bs_valid_o cycle, so a read
    // issued in that same cycle still sees the previous contents.
    // ------------------------------------------------------------------
    logic [1:0] rf [256];
    logic       wr_en;
    logic       done_fired;

    assign wr_en = bs_valid_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++)
                rf[i] <= 2'd0;
            bs_rdata_o <= 2'd0;
        end else begin
            bs_rdata_o <= rf[bs_raddr_i];
            if (wr_en)
                rf[wr_addr] <= bs_o;
        end
    end

    // done_fired blocks a second pulse until the next pass writes address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bs_done_o  <= 1'b0;
            done_fired <= 1'b0;
        end else begin
            bs_done_o <= 1'b0;
            if (wr_en && (wr_addr == 8'd0))
                done_fired <= 1'b0;
            if (wr_en && (wr_addr == 8'd255) && !done_fired) begin
                bs_done_o  <= 1'b1;
                done_fired <= 1'b1;
            end
        end
    end

`ifdef DB_BS_STAT_EN
    function automatic logic [8:0] sat_inc(input logic [8:0] c);
        return (c >= 9'd256) ? 9'd256 : c + 9'd1;
    endfunction

    // Writing address 0 starts a new pass: counts restart from that sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bs2_cnt_o <= '0;
            bs1_cnt_o <= '0;
            bs0_cnt_o <= '0;
        end else if (wr_en) begin
            if (wr_addr == 8'd0) begin
                bs2_cnt_o <= (bs_o == 2'd2) ? 9'd1 : 9'd0;
                bs1_cnt_o <= (bs_o == 2'd1) ? 9'd1 : 9'd0;
                bs0_cnt_o <= (bs_o == 2'd0) ? 9'd1 : 9'd0;
            end else begin
                if (bs_o == 2'd2) bs2_cnt_o <= sat_inc(bs2_cnt_o);
                if (bs_o == 2'd1) bs1_cnt_o <= sat_inc(bs1_cnt_o);
                if (bs_o == 2'd0) bs0_cnt_o <= sat_inc(bs0_cnt_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_db_bs.sv
// tb/tb_db_bs.sv - directed self-checking bench for db_bs

`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif
`ifndef PIC_Y_WIDTH
`define PIC_Y_WIDTH 8
`endif

module tb_db_bs;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_DBY  = 3'b011;
    // flag vector layout {tu, pu, cbf_p, cbf_q, intra_p, intra_q}
    localparam logic [5:0] F_TU = 6'b100000, F_PU = 6'b010000, F_CBFP = 6'b001000,
                           F_CBFQ = 6'b000100, F_IP = 6'b000010, F_IQ = 6'b000001;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [2:0]              state_i;
    logic [8:0]              cnt_i;
    logic [`PIC_X_WIDTH-1:0] sys_ctu_x_i;
    logic [`PIC_Y_WIDTH-1:0] sys_ctu_y_i;
    logic [19:0]             mv_p_i, mv_q_i;
    logic                    edge_tu_i, edge_pu_i, cbf_p_i, cbf_q_i, intra_p_i, intra_q_i;
    logic [7:0]              bs_raddr_i;
    logic [1:0]              bs_rdata_o, bs_o;
    logic                    bs_valid_o, bs_done_o;
`ifdef DB_BS_STAT_EN
    logic [8:0]              bs2_cnt, bs1_cnt, bs0_cnt;
`endif

    always #5 clk = ~clk;

    db_bs #(.MV_W(10), .MV_THR(4)) dut (
        .clk(clk), .rst(rst), .state_i(state_i), .cnt_i(cnt_i),
        .sys_ctu_x_i(sys_ctu_x_i), .sys_ctu_y_i(sys_ctu_y_i),
        .mv_p_i(mv_p_i), .mv_q_i(mv_q_i),
        .edge_tu_i(edge_tu_i), .edge_pu_i(edge_pu_i),
        .cbf_p_i(cbf_p_i), .cbf_q_i(cbf_q_i),
        .intra_p_i(intra_p_i), .intra_q_i(intra_q_i),
        .bs_raddr_i(bs_raddr_i), .bs_rdata_o(bs_rdata_o),
        .bs_o(bs_o), .bs_valid_o(bs_valid_o), .bs_done_o(bs_done_o)
`ifdef DB_BS_STAT_EN
        , .bs2_cnt_o(bs2_cnt), .bs1_cnt_o(bs1_cnt), .bs0_cnt_o(bs0_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] s_mvp [256];
    logic [19:0] s_mvq [256];
    logic [5:0]  s_fl  [256];
    logic [1:0]  got_bs [256];
    logic        got_v  [256];
    logic        vlog   [300];
    logic [1:0]  bslog  [300];
    logic [1:0]  rdlog  [300];
    int          done_count, done_cycle;

    function automatic logic [19:0] mv(input int x, input int y);
        return {10'(x), 10'(y)};
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < 256; i++) begin
            s_mvp[i] = '0;
            s_mvq[i] = '0;
            s_fl[i]  = '0;
        end
    endtask

    task automatic idle_inputs();
        state_i = ST_IDLE;
        cnt_i   = '0;
        mv_p_i  = '0;
        mv_q_i  = '0;
        {edge_tu_i, edge_pu_i, cbf_p_i, cbf_q_i, intra_p_i, intra_q_i} = '0;
    endtask

    // Plays one DBY pass: cnt_i=k in cycle k, stimulus for cnt k arrives in
    // cycle k+2. Outputs are logged on the falling edge. rst_at>=0 asserts
    // reset in that cycle and returns immediately.
    task automatic drive_pass(input int ncyc, input int rst_at);
        done_count = 0;
        done_cycle = -1;
        for (int i = 0; i < 256; i++) got_v[i] = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            state_i = (k < 256) ? ST_DBY : ST_IDLE;
            cnt_i   = 9'(k);
            if (k >= 2 && k - 2 < 256) begin
                mv_p_i = s_mvp[k-2];
                mv_q_i = s_mvq[k-2];
                {edge_tu_i, edge_pu_i, cbf_p_i, cbf_q_i, intra_p_i, intra_q_i} = s_fl[k-2];
            end else begin
                mv_p_i = '0;
                mv_q_i = '0;
                {edge_tu_i, edge_pu_i, cbf_p_i, cbf_q_i, intra_p_i, intra_q_i} = '0;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                return;
            end
            @(negedge clk);
            vlog[k]  = bs_valid_o;
            bslog[k] = bs_o;
            rdlog[k] = bs_rdata_o;
            if (bs_valid_o && k >= 4 && k - 4 < 256) begin
                got_v[k-4]  = 1'b1;
                got_bs[k-4] = bs_o;
            end
            if (bs_done_o) begin
                done_count++;
                done_cycle = k;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic read_rf(input logic [7:0] addr, output logic [1:0] v);
        bs_raddr_i = addr;
        @(posedge clk); #1;
        v = bs_rdata_o;
    endtask

    task automatic test_reset();
        logic [1:0] v;
        rst = 1'b1;
        idle_inputs();
        sys_ctu_x_i = 1;
        sys_ctu_y_i = 1;
        bs_raddr_i  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bs_o, bs_valid_o, bs_done_o, bs_rdata_o} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got bs=%0d v=%0d done=%0d rd=%0d, want all 0",
                     bs_o, bs_valid_o, bs_done_o, bs_rdata_o);
        end
        rst = 1'b0;
        read_rf(8'd0, v);
        n_cmp++;
        if (v !== 2'd0) begin n_bad++; $display("FAIL reset_rf0: got %0d want 0", v); end
        read_rf(8'd255, v);
        n_cmp++;
        if (v !== 2'd0) begin n_bad++; $display("FAIL reset_rf255: got %0d want 0", v); end
    endtask

    task automatic test_intra_edge();
        logic [1:0] v;
        clear_stim();
        for (int i = 0; i < 256; i++) s_fl[i] = F_PU | F_IQ;
        sys_ctu_x_i = 1;
        sys_ctu_y_i = 1;
        drive_pass(266, -1);
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (got_v[i] !== 1'b1 || got_bs[i] !== 2'd2) begin
                n_bad++;
                $display("FAIL intra_bs[%0d]: got valid=%0d bs=%0d want valid=1 bs=2", i, got_v[i], got_bs[i]);
            end
        end
        n_cmp++;
        if (done_count !== 1 || done_cycle !== 260) begin
            n_bad++;
            $display("FAIL intra_done: got count=%0d cycle=%0d want count=1 cycle=260", done_count, done_cycle);
        end
        for (int i = 0; i < 256; i++) begin
            read_rf(8'(i), v);
            n_cmp++;
            if (v !== 2'd2) begin n_bad++; $display("FAIL intra_rf[%0d]: got %0d want 2", i, v); end
        end
`ifdef DB_BS_STAT_EN
        n_cmp++;
        if (bs2_cnt !== 9'd256 || bs1_cnt !== 9'd0 || bs0_cnt !== 9'd0) begin
            n_bad++;
            $display("FAIL intra_stat: got %0d/%0d/%0d want 256/0/0", bs2_cnt, bs1_cnt, bs0_cnt);
        end
`endif
    endtask

    task automatic test_mv_threshold();
        int         addr [5] = '{20, 21, 22, 23, 100};
        logic [1:0] exp  [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        logic [1:0] v;
        clear_stim();
        s_fl[20] = F_PU; s_mvp[20] = mv(0, 0);    s_mvq[20] = mv(3, -3);
        s_fl[21] = F_PU; s_mvp[21] = mv(0, 0);    s_mvq[21] = mv(4, 0);
        s_fl[22] = F_PU; s_mvp[22] = mv(0, 0);    s_mvq[22] = mv(0, -4);
        s_fl[23] = F_PU; s_mvp[23] = mv(-512, 0); s_mvq[23] = mv(511, 0);
        sys_ctu_x_i = 1;
        sys_ctu_y_i = 1;
        drive_pass(266, -1);
        for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (got_bs[addr[j]] !== exp[j]) begin
                n_bad++;
                $display("FAIL mv_thr[%0d]: got %0d want %0d", addr[j], got_bs[addr[j]], exp[j]);
            end
        end
        // entry 100 held 2 from the previous pass and must be overwritten
        read_rf(8'd100, v);
        n_cmp++;
        if (v !== 2'd0) begin n_bad++; $display("FAIL mv_overwrite_rf100: got %0d want 0", v); end
    endtask

    task automatic test_cbf_rule();
        int         addr [5] = '{30, 31, 32, 33, 34};
        logic [1:0] exp  [5] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        clear_stim();
        s_fl[30] = F_TU | F_CBFP; s_mvp[30] = mv(5, 5);  s_mvq[30] = mv(5, 5);
        s_fl[31] = F_PU | F_CBFP; s_mvp[31] = mv(5, 5);  s_mvq[31] = mv(5, 5);
        s_fl[32] = F_IP;
        s_fl[33] = F_TU | F_CBFQ; s_mvp[33] = mv(-7, 2); s_mvq[33] = mv(-7, 2);
        s_fl[34] = F_PU | F_CBFP; s_mvp[34] = mv(0, 0);  s_mvq[34] = mv(0, 4);
        sys_ctu_x_i = 1;
        sys_ctu_y_i = 1;
        drive_pass(266, -1);
        for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (got_bs[addr[j]] !== exp[j]) begin
                n_bad++;
                $display("FAIL cbf[%0d]: got %0d want %0d", addr[j], got_bs[addr[j]], exp[j]);
            end
        end
    endtask

    task automatic test_pic_boundary();
        int         addr_a [6] = '{0, 1, 2, 3, 4, 32};
        logic [1:0] exp_a  [6] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
        int         addr_b [6] = '{0, 1, 2, 3, 6, 34};
        logic [1:0] exp_b  [6] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2};
        clear_stim();
        for (int i = 0; i < 256; i++) s_fl[i] = F_PU | F_IP;
        sys_ctu_x_i = 0;
        sys_ctu_y_i = 1;
        drive_pass(266, -1);
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (got_bs[addr_a[j]] !== exp_a[j]) begin
                n_bad++;
                $display("FAIL pic_left[%0d]: got %0d want %0d", addr_a[j], got_bs[addr_a[j]], exp_a[j]);
            end
        end
        sys_ctu_x_i = 1;
        sys_ctu_y_i = 0;
        drive_pass(266, -1);
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (got_bs[addr_b[j]] !== exp_b[j]) begin
                n_bad++;
                $display("FAIL pic_top[%0d]: got %0d want %0d", addr_b[j], got_bs[addr_b[j]], exp_b[j]);
            end
        end
    endtask

    task automatic test_timing_read();
        sys_ctu_x_i = 1;
        sys_ctu_y_i = 1;
        clear_stim();
        drive_pass(266, -1);          // rf now all 0
        clear_stim();
        s_fl[10] = F_PU | F_IQ;       // only cnt 10 yields a nonzero BS
        bs_raddr_i = 8'd10;
        drive_pass(266, -1);
        n_cmp++;
        if (vlog[3] !== 1'b0 || vlog[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL first_valid: got v3=%0d v4=%0d want 0/1", vlog[3], vlog[4]);
        end
        n_cmp++;
        if (bslog[13] !== 2'd0 || bslog[14] !== 2'd2 || bslog[15] !== 2'd0) begin
            n_bad++;
            $display("FAIL bs_at_cnt14: got %0d/%0d/%0d want 0/2/0", bslog[13], bslog[14], bslog[15]);
        end
        n_cmp++;
        if (rdlog[15] !== 2'd0) begin
            n_bad++;
            $display("FAIL read_during_write: got %0d want 0 (old)", rdlog[15]);
        end
        n_cmp++;
        if (rdlog[16] !== 2'd2) begin
            n_bad++;
            $display("FAIL read_after_write: got %0d want 2", rdlog[16]);
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [1:0] v;
        clear_stim();
        for (int i = 0; i < 256; i++) s_fl[i] = F_PU | F_IQ;
        sys_ctu_x_i = 1;
        sys_ctu_y_i = 1;
        bs_raddr_i  = 8'd50;
        drive_pass(266, 100);
        n_cmp++;
        if ({bs_o, bs_valid_o, bs_done_o, bs_rdata_o} !== 6'b0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got bs=%0d v=%0d done=%0d rd=%0d, want all 0",
                     bs_o, bs_valid_o, bs_done_o, bs_rdata_o);
        end
`ifdef DB_BS_STAT_EN
        n_cmp++;
        if (bs2_cnt !== 9'd0 || bs1_cnt !== 9'd0 || bs0_cnt !== 9'd0) begin
            n_bad++;
            $display("FAIL midrst_stat: got %0d/%0d/%0d want 0/0/0", bs2_cnt, bs1_cnt, bs0_cnt);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        n_cmp++;
        if (done_count !== 0) begin n_bad++; $display("FAIL midrst_done: got %0d pulses want 0", done_count); end
        read_rf(8'd50, v);
        n_cmp++;
        if (v !== 2'd0) begin n_bad++; $display("FAIL midrst_rf50: got %0d want 0", v); end
        read_rf(8'd0, v);
        n_cmp++;
        if (v !== 2'd0) begin n_bad++; $display("FAIL midrst_rf0: got %0d want 0", v); end
        drive_pass(266, -1);
        n_cmp++;
        if (done_count !== 1 || done_cycle !== 260) begin
            n_bad++;
            $display("FAIL after_rst_done: got count=%0d cycle=%0d want 1/260", done_count, done_cycle);
        end
        read_rf(8'd50, v);
        n_cmp++;
        if (v !== 2'd2) begin n_bad++; $display("FAIL after_rst_rf50: got %0d want 2", v); end
        read_rf(8'd255, v);
        n_cmp++;
        if (v !== 2'd2) begin n_bad++; $display("FAIL after_rst_rf255: got %0d want 2", v); end
`ifdef DB_BS_STAT_EN
        n_cmp++;
        if (32'(bs2_cnt) + 32'(bs1_cnt) + 32'(bs0_cnt) !== 256 || bs2_cnt !== 9'd256) begin
            n_bad++;
            $display("FAIL after_rst_stat: got %0d/%0d/%0d want 256/0/0", bs2_cnt, bs1_cnt, bs0_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_intra_edge();
        test_mv_threshold();
        test_cbf_rule();
        test_pic_boundary();
        test_timing_read();
        test_reset_mid_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
